// File: rtl/dram_arbiter.sv
// -----------------------------------------------------------------------------
// dram_arbiter
//
// Serialises up to two same-cycle memory requests from a dual-issue memory
// stage onto a single data-RAM port. Slot 1 (the older instruction) is always
// issued before slot 2, so a store in slot 1 is visible to a load in slot 2.
// The RAM has a one-cycle read latency. After the last issue the block gives
// a one-cycle response pulse carrying the load data for both slots.
//
// Optional feature: define DRAM_ARB_PERF_EN to build a saturating 32-bit
// counter of stalled cycles on stall_cycles_o. Without it the output is 0.
//
// Ports
//   clk, rst                 core clock, synchronous active-high reset
//   ce_i_1/2, we_i_1/2       slot request valid / store(1) or load(0)
//   addr_i_1/2, sel_i_1/2    byte address / byte-lane enables
//   data_i_1/2, pc_i_1/2     store data / PC of the requesting instruction
//   flush_i                  pipeline flush, drops slots not yet issued
//   stall_o                  holds the CPU memory stage
//   resp_valid_o             one-cycle pulse, rdata_o_1/2 valid
//   rdata_o_1/2              load data per slot (0 for stores / idle slots)
//   ram_ce_o, ram_we_o       RAM port enable / write enable
//   ram_addr_o, ram_data_o   RAM address / write data
//   ram_sel_o, ram_pc_o      RAM byte-lane enables / PC
//   ram_data_i               RAM read data, valid the cycle after a read
//   stall_cycles_o           stall performance counter
// -----------------------------------------------------------------------------
module dram_arbiter (
  input  logic        clk,
  input  logic        rst,
  input  logic        ce_i_1,
  input  logic        ce_i_2,
  input  logic        we_i_1,
  input  logic        we_i_2,
  input  logic [31:0] addr_i_1,
  input  logic [31:0] addr_i_2,
  input  logic [3:0]  sel_i_1,
  input  logic [3:0]  sel_i_2,
  input  logic [31:0] data_i_1,
  input  logic [31:0] data_i_2,
  input  logic [31:0] pc_i_1,
  input  logic [31:0] pc_i_2,
  input  logic        flush_i,
  output logic        stall_o,
  output logic        resp_valid_o,
  output logic [31:0] rdata_o_1,
  output logic [31:0] rdata_o_2,
  output logic        ram_ce_o,
  output logic        ram_we_o,
  output logic [31:0] ram_addr_o,
  output logic [31:0] ram_data_o,
  output logic [31:0] ram_pc_o,
  output logic [3:0]  ram_sel_o,
  input  logic [31:0] ram_data_i,
  output logic [31:0] stall_cycles_o
);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_ISSUE1 = 2'd1,
    S_ISSUE2 = 2'd2,
    S_RESP   = 2'd3
  } state_t;

  state_t      r_state;
  logic        r_p1, r_p2;           // slot still waiting to be issued
  logic        r_we_1, r_we_2;
  logic [31:0] r_addr_1, r_addr_2;
  logic [3:0]  r_sel_1, r_sel_2;
  logic [31:0] r_data_1, r_data_2;
  logic [31:0] r_pc_1, r_pc_2;
  logic        r_live_1, r_live_2;   // a load of this slot was issued last cycle
  logic [31:0] r_rdata_1, r_rdata_2;
  logic        r_resp_valid;
  logic        w_stall;

  // NOTE: all state below is updated with non-blocking assignments so every
  // register samples the pre-edge values; where two assignments to the same
  // register occur in one pass, the later one (e.g. clearing rdata on a new
  // acceptance) intentionally wins.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state      <= S_IDLE;
      r_p1         <= 1'b0;
      r_p2         <= 1'b0;
      r_we_1       <= 1'b0;
      r_we_2       <= 1'b0;
      r_addr_1     <= '0;
      r_addr_2     <= '0;
      r_sel_1      <= '0;
      r_sel_2      <= '0;
      r_data_1     <= '0;
      r_data_2     <= '0;
      r_pc_1       <= '0;
      r_pc_2       <= '0;
      r_live_1     <= 1'b0;
      r_live_2     <= 1'b0;
      r_rdata_1    <= '0;
      r_rdata_2    <= '0;
      r_resp_valid <= 1'b0;
    end else begin
      r_resp_valid <= 1'b0;
      r_live_1     <= 1'b0;
      r_live_2     <= 1'b0;
      // RAM data is only present for one cycle; keep a copy for later cycles.
      if (r_live_1) r_rdata_1 <= ram_data_i;
      if (r_live_2) r_rdata_2 <= ram_data_i;

      case (r_state)
        S_IDLE: begin
          if (!flush_i && (ce_i_1 || ce_i_2)) begin
            r_p1      <= ce_i_1;
            r_p2      <= ce_i_2;
            r_we_1    <= we_i_1;
            r_we_2    <= we_i_2;
            r_addr_1  <= addr_i_1;
            r_addr_2  <= addr_i_2;
            r_sel_1   <= sel_i_1;
            r_sel_2   <= sel_i_2;
            r_data_1  <= data_i_1;
            r_data_2  <= data_i_2;
            r_pc_1    <= pc_i_1;
            r_pc_2    <= pc_i_2;
            r_rdata_1 <= '0;
            r_rdata_2 <= '0;
            r_state   <= ce_i_1 ? S_ISSUE1 : S_ISSUE2;
          end
        end
        S_ISSUE1: begin
          // Slot 1 is on the RAM this cycle; a flush cannot retract it.
          r_p1     <= 1'b0;
          r_live_1 <= r_p1 & ~r_we_1;
          if (flush_i) begin
            r_p2    <= 1'b0;
            r_state <= S_IDLE;
          end else if (r_p2) begin
            r_state <= S_ISSUE2;
          end else begin
            r_state      <= S_RESP;
            r_resp_valid <= 1'b1;
          end
        end
        S_ISSUE2: begin
          r_p2     <= 1'b0;
          r_live_2 <= r_p2 & ~r_we_2;
          if (flush_i) begin
            r_state <= S_IDLE;
          end else begin
            r_state      <= S_RESP;
            r_resp_valid <= 1'b1;
          end
        end
        S_RESP:  r_state <= S_IDLE;
        default: r_state <= S_IDLE;
      endcase
    end
  end

  // RAM port: a straight mux of the latched slot selected by the state
  // register, forced to all-zero whenever no slot is being issued.
  // NOTE: every output is given a default before the case so no latch is
  // inferred for the states that do not drive the port.
  always_comb begin
    ram_ce_o   = 1'b0;
    ram_we_o   = 1'b0;
    ram_addr_o = '0;
    ram_data_o = '0;
    ram_pc_o   = '0;
    ram_sel_o  = '0;
    case (r_state)
      S_ISSUE1: begin
        ram_ce_o   = 1'b1;
        ram_we_o   = r_we_1;
        ram_addr_o = r_addr_1;
        ram_data_o = r_data_1;
        ram_pc_o   = r_pc_1;
        ram_sel_o  = r_sel_1;
      end
      S_ISSUE2: begin
        ram_ce_o   = 1'b1;
        ram_we_o   = r_we_2;
        ram_addr_o = r_addr_2;
        ram_data_o = r_data_2;
        ram_pc_o   = r_pc_2;
        ram_sel_o  = r_sel_2;
      end
      default: ;
    endcase
  end

  // The last load issued returns its data in the RESP cycle itself, so that
  // slot forwards the RAM bus directly; earlier loads come from the copy.
  assign rdata_o_1 = r_live_1 ? ram_data_i : r_rdata_1;
  assign rdata_o_2 = r_live_2 ? ram_data_i : r_rdata_2;

  assign resp_valid_o = r_resp_valid;

  // Stall must react in the request cycle, hence the input term in IDLE.
  assign w_stall = !rst && (((r_state == S_IDLE) && (ce_i_1 || ce_i_2)) ||
                            (r_state == S_ISSUE1) || (r_state == S_ISSUE2));
  assign stall_o = w_stall;

`ifdef DRAM_ARB_PERF_EN
  logic [31:0] r_stall_cycles;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_stall_cycles <= '0;
    end else if (w_stall && (r_stall_cycles != 32'hFFFF_FFFF)) begin
      r_stall_cycles <= r_stall_cycles + 32'd1;
    end
  end

  assign stall_cycles_o = r_stall_cycles;
`else
  assign stall_cycles_o = '0;
`endif

endmodule

// File: tb/tb_dram_arbiter.sv
// -----------------------------------------------------------------------------
// tb_dram_arbiter
//
// Self-checking bench for dram_arbiter. A word-addressed RAM model answers the
// DUT's RAM port. A transaction-level reference (a queue of slots still to be
// issued plus a word memory) predicts every output on every cycle; a few
// directed scenarios additionally pin hand-computed literal values.
// -----------------------------------------------------------------------------
module tb_dram_arbiter;

  logic        clk;
  logic        rst;
  logic        ce1, ce2, we1, we2, flush;
  logic [31:0] addr1, addr2, data1, data2, pc1, pc2;
  logic [3:0]  sel1, sel2;
  logic        stall_o, resp_valid_o;
  logic [31:0] rdata_o_1, rdata_o_2;
  logic        ram_ce_o, ram_we_o;
  logic [31:0] ram_addr_o, ram_data_o, ram_pc_o;
  logic [3:0]  ram_sel_o;
  logic [31:0] ram_data_i;
  logic [31:0] stall_cycles_o;

  int n_cmp  = 0;
  int n_fail = 0;

  dram_arbiter dut (
    .clk            (clk),
    .rst            (rst),
    .ce_i_1         (ce1),
    .ce_i_2         (ce2),
    .we_i_1         (we1),
    .we_i_2         (we2),
    .addr_i_1       (addr1),
    .addr_i_2       (addr2),
    .sel_i_1        (sel1),
    .sel_i_2        (sel2),
    .data_i_1       (data1),
    .data_i_2       (data2),
    .pc_i_1         (pc1),
    .pc_i_2         (pc2),
    .flush_i        (flush),
    .stall_o        (stall_o),
    .resp_valid_o   (resp_valid_o),
    .rdata_o_1      (rdata_o_1),
    .rdata_o_2      (rdata_o_2),
    .ram_ce_o       (ram_ce_o),
    .ram_we_o       (ram_we_o),
    .ram_addr_o     (ram_addr_o),
    .ram_data_o     (ram_data_o),
    .ram_pc_o       (ram_pc_o),
    .ram_sel_o      (ram_sel_o),
    .ram_data_i     (ram_data_i),
    .stall_cycles_o (stall_cycles_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: actual=%h required=%h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] merge(input logic [31:0] old_w, input logic [31:0] new_w,
                                        input logic [3:0] sel);
    logic [31:0] r;
    r = old_w;
    for (int b = 0; b < 4; b++) if (sel[b]) r[8*b +: 8] = new_w[8*b +: 8];
    return r;
  endfunction

  // ---------------- RAM attached to the DUT port ----------------
  logic [31:0] ram_mem [16];

  initial ram_data_i = '0;

  always @(posedge clk) begin : ram_port
    if (ram_ce_o && ram_we_o)
      ram_mem[ram_addr_o[5:2]] <= merge(ram_mem[ram_addr_o[5:2]], ram_data_o, ram_sel_o);
    if (ram_ce_o && !ram_we_o) ram_data_i <= ram_mem[ram_addr_o[5:2]];
    else                       ram_data_i <= $urandom;   // junk when no read
  end

  // ---------------- transaction-level reference ----------------
  logic [31:0] m_mem [16];
  int          iq[$];                  // slots still to be put on the RAM
  bit          m_resp;
  bit          m_en = 1'b0;
  logic        m_we   [1:2];
  logic [31:0] m_addr [1:2];
  logic [31:0] m_data [1:2];
  logic [31:0] m_pc   [1:2];
  logic [3:0]  m_sel  [1:2];
  logic [31:0] m_rd   [1:2];
  logic [31:0] m_cnt = '0;

  always @(negedge clk) begin : compare
    logic        e_ce, e_we, e_stall, e_resp;
    logic [31:0] e_addr, e_data, e_pc;
    logic [3:0]  e_sel;
    int          s;
    if (m_en) begin
      e_ce = 0; e_we = 0; e_stall = 0; e_resp = 0;
      e_addr = '0; e_data = '0; e_pc = '0; e_sel = '0; s = 0;
      if (iq.size() > 0) begin
        s       = iq[0];
        e_ce    = 1'b1;
        e_we    = m_we[s];
        e_addr  = m_addr[s];
        e_data  = m_data[s];
        e_pc    = m_pc[s];
        e_sel   = m_sel[s];
        e_stall = 1'b1;
      end else if (m_resp) begin
        e_resp = 1'b1;
      end else begin
        e_stall = ce1 | ce2;
      end
      if (rst) e_stall = 1'b0;

      check("ram_ce",     32'(ram_ce_o),     32'(e_ce));
      check("ram_we",     32'(ram_we_o),     32'(e_we));
      check("ram_addr",   ram_addr_o,        e_addr);
      check("ram_data",   ram_data_o,        e_data);
      check("ram_pc",     ram_pc_o,          e_pc);
      check("ram_sel",    32'(ram_sel_o),    32'(e_sel));
      check("stall",      32'(stall_o),      32'(e_stall));
      check("resp_valid", 32'(resp_valid_o), 32'(e_resp));
      if (e_resp) begin
        check("rdata_1", rdata_o_1, m_rd[1]);
        check("rdata_2", rdata_o_2, m_rd[2]);
      end
`ifdef DRAM_ARB_PERF_EN
      check("stall_cycles", stall_cycles_o, m_cnt);
`else
      check("stall_cycles", stall_cycles_o, 32'd0);
`endif

      // advance to the next cycle
      if (iq.size() > 0) begin
        if (m_we[s]) m_mem[m_addr[s][5:2]] = merge(m_mem[m_addr[s][5:2]], m_data[s], m_sel[s]);
        else         m_rd[s] = m_mem[m_addr[s][5:2]];
        void'(iq.pop_front());
        if (flush)                iq.delete();
        else if (iq.size() == 0)  m_resp = 1'b1;
      end else if (m_resp) begin
        m_resp = 1'b0;
      end else if (!flush && (ce1 || ce2)) begin
        m_we[1] = we1;   m_we[2] = we2;
        m_addr[1] = addr1; m_addr[2] = addr2;
        m_data[1] = data1; m_data[2] = data2;
        m_pc[1] = pc1;   m_pc[2] = pc2;
        m_sel[1] = sel1; m_sel[2] = sel2;
        m_rd[1] = '0;    m_rd[2] = '0;
        if (ce1) iq.push_back(1);
        if (ce2) iq.push_back(2);
      end
      if (rst) begin
        iq.delete();
        m_resp = 1'b0;
        m_cnt  = '0;
      end else if (e_stall && (m_cnt != 32'hFFFF_FFFF)) begin
        m_cnt = m_cnt + 32'd1;
      end
    end
  end

  // ---------------- stimulus ----------------
  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic quiet();
    ce1 = 0; ce2 = 0; flush = 0;
  endtask

  task automatic set_slot1(input logic we, input logic [31:0] a, input logic [31:0] d,
                           input logic [3:0] s, input logic [31:0] p);
    ce1 = 1; we1 = we; addr1 = a; data1 = d; sel1 = s; pc1 = p;
  endtask

  task automatic set_slot2(input logic we, input logic [31:0] a, input logic [31:0] d,
                           input logic [3:0] s, input logic [31:0] p);
    ce2 = 1; we2 = we; addr2 = a; data2 = d; sel2 = s; pc2 = p;
  endtask

  initial begin
    logic [31:0] w;
    rst = 1; ce1 = 0; ce2 = 0; we1 = 0; we2 = 0; flush = 0;
    addr1 = '0; addr2 = '0; data1 = '0; data2 = '0; pc1 = '0; pc2 = '0;
    sel1 = '0; sel2 = '0;
    for (int i = 0; i < 16; i++) begin
      w = $urandom;
      ram_mem[i] = w;
      m_mem[i]   = w;
    end
    ram_mem[4] = 32'hDEADBEEF;
    m_mem[4]   = 32'hDEADBEEF;

    cyc();
    m_en = 1'b1;
    cyc();
    #2;
    check("rst_stall",      32'(stall_o),      32'd0);
    check("rst_resp",       32'(resp_valid_o), 32'd0);
    check("rst_rdata_1",    rdata_o_1,         32'd0);
    check("rst_ram_ce",     32'(ram_ce_o),     32'd0);
    check("rst_stall_cnt",  stall_cycles_o,    32'd0);
    cyc();
    rst = 0;

    // A: single slot-1 load, RAM returns DEADBEEF, latency 2
    cyc();
    set_slot1(0, 32'h1c000010, 32'h0, 4'hF, 32'h0000_1000);
    #2 check("A_stall_accept", 32'(stall_o), 32'd1);
    cyc(); quiet();
    #2 check("A_issue_ce",   32'(ram_ce_o), 32'd1);
    check("A_issue_addr",    ram_addr_o,    32'h1c000010);
    cyc();
    #2 check("A_resp",       32'(resp_valid_o), 32'd1);
    check("A_rdata_1",       rdata_o_1,     32'hDEADBEEF);
    check("A_rdata_2",       rdata_o_2,     32'd0);
    check("A_stall_resp",    32'(stall_o),  32'd0);
    cyc();
    #2 check("A_resp_end",   32'(resp_valid_o), 32'd0);

    // B: store(1) then load(2) to the same word, latency 3
    cyc();
    set_slot1(1, 32'h0000_0100, 32'h12345678, 4'hF, 32'h0000_2000);
    set_slot2(0, 32'h0000_0100, 32'h0,        4'hF, 32'h0000_2004);
    #2 check("B_stall_c0", 32'(stall_o), 32'd1);
    cyc(); quiet();
    #2 check("B_write_first", 32'(ram_we_o), 32'd1);
    check("B_write_data",     ram_data_o,    32'h12345678);
    check("B_stall_c1",       32'(stall_o),  32'd1);
    cyc();
    #2 check("B_read_second", 32'(ram_we_o), 32'd0);
    check("B_read_ce",        32'(ram_ce_o), 32'd1);
    check("B_stall_c2",       32'(stall_o),  32'd1);
    cyc();
    #2 check("B_resp",        32'(resp_valid_o), 32'd1);
    check("B_rdata_2",        rdata_o_2,     32'h12345678);
    check("B_rdata_1",        rdata_o_1,     32'd0);
    check("B_stall_c3",       32'(stall_o),  32'd0);

    // C: slot-2-only load, PC of slot 2 on the RAM
    cyc();
    set_slot2(0, 32'h0000_0008, 32'h0, 4'h3, 32'hCAFE_0004);
    cyc(); quiet();
    #2 check("C_issue_pc",  ram_pc_o,       32'hCAFE_0004);
    check("C_issue_addr",   ram_addr_o,     32'h0000_0008);
    cyc();
    #2 check("C_resp",      32'(resp_valid_o), 32'd1);

    // D: two slots, flush during ISSUE1
    cyc();
    set_slot1(1, 32'h0000_0020, 32'hA5A5A5A5, 4'hF, 32'h0000_3000);
    set_slot2(0, 32'h0000_0024, 32'h0,        4'hF, 32'h0000_3004);
    cyc(); quiet(); flush = 1;
    #2 check("D_write_we",  32'(ram_we_o), 32'd1);
    check("D_write_data",   ram_data_o,    32'hA5A5A5A5);
    cyc(); flush = 0;
    #2 check("D_no_issue2", 32'(ram_ce_o), 32'd0);
    check("D_no_resp",      32'(resp_valid_o), 32'd0);
    check("D_idle_stall",   32'(stall_o),  32'd0);
    cyc();
    #2 check("D_no_resp_2", 32'(resp_valid_o), 32'd0);
    check("D_ram_written",  ram_mem[8],    32'hA5A5A5A5);

    // E: reset during ISSUE2, then counter after one two-slot transaction
    cyc();
    set_slot1(0, 32'h0000_0030, 32'h0, 4'hF, 32'h0000_4000);
    set_slot2(0, 32'h0000_0034, 32'h0, 4'hF, 32'h0000_4004);
    cyc(); quiet();
    cyc(); rst = 1;
    cyc(); rst = 0;
    #2 check("E_ram_ce",    32'(ram_ce_o),  32'd0);
    check("E_ram_addr",     ram_addr_o,     32'd0);
    check("E_ram_pc",       ram_pc_o,       32'd0);
    check("E_resp",         32'(resp_valid_o), 32'd0);
    check("E_stall",        32'(stall_o),   32'd0);
    check("E_rdata_2",      rdata_o_2,      32'd0);
    check("E_cnt_zero",     stall_cycles_o, 32'd0);
    cyc();
    set_slot1(0, 32'h0000_0030, 32'h0, 4'hF, 32'h0000_5000);
    set_slot2(0, 32'h0000_0034, 32'h0, 4'hF, 32'h0000_5004);
    cyc(); quiet();
    cyc();
    cyc();
    #2 check("E_resp_two",  32'(resp_valid_o), 32'd1);
`ifdef DRAM_ARB_PERF_EN
    check("E_cnt_three",    stall_cycles_o, 32'd3);
`else
    check("E_cnt_tied",     stall_cycles_o, 32'd0);
`endif

    // Random traffic
    for (int c = 0; c < 3000; c++) begin
      cyc();
      rst   = ($urandom_range(0, 199) == 0);
      flush = ($urandom_range(0, 15) == 0);
      ce1   = ($urandom_range(0, 9) < 4);
      ce2   = ($urandom_range(0, 9) < 4);
      we1   = 1'($urandom_range(0, 1));
      we2   = 1'($urandom_range(0, 1));
      addr1 = ($urandom & 32'hFFFF_FFC0) | {26'd0, 4'($urandom_range(0, 15)), 2'b00};
      addr2 = ($urandom & 32'hFFFF_FFC0) | {26'd0, 4'($urandom_range(0, 15)), 2'b00};
      data1 = $urandom;
      data2 = $urandom;
      sel1  = 4'($urandom);
      sel2  = 4'($urandom);
      pc1   = $urandom;
      pc2   = $urandom;
    end
    cyc(); quiet(); rst = 0;
    repeat (6) cyc();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/dram_arbiter.md
DRAM_ARBITER -- requirements
Module: dram_arbiter

Interface
REQ-001 clk  input  1  core clock; all state updates on rising edge.
REQ-002 rst  input  1  synchronous, active-high reset.
REQ-003 ce_i_1/ce_i_2  input  1  slot 1 / slot 2 memory request valid; slot 1 is the older instruction.
REQ-004 we_i_1/we_i_2  input  1  1 = store, 0 = load.
REQ-005 addr_i_1/addr_i_2  input  32  byte address.
REQ-006 sel_i_1/sel_i_2  input  4  byte-lane enables.
REQ-007 data_i_1/data_i_2  input  32  store data.
REQ-008 pc_i_1/pc_i_2  input  32  PC of the requesting instruction.
REQ-009 flush_i  input  1  pipeline flush; aborts un-issued slots.
REQ-010 stall_o  output  1  holds the CPU memory stage.
REQ-011 resp_valid_o  output  1  one-cycle pulse; rdata outputs are valid.
REQ-012 rdata_o_1/rdata_o_2  output  32  load data for slot 1 / slot 2.
REQ-013 ram_ce_o, ram_we_o  output  1  single data-RAM port enable and write enable.
REQ-014 ram_addr_o, ram_data_o, ram_pc_o  output  32  RAM address, write data, PC.
REQ-015 ram_sel_o  output  4  RAM byte-lane enables.
REQ-016 ram_data_i  input  32  RAM read data, valid one cycle after a read is issued.
REQ-017 stall_cycles_o  output  32  performance counter (see Configuration).

Function
REQ-018 The block shall serialise two same-cycle requests onto one RAM port; the FSM states are IDLE, ISSUE1, ISSUE2 and RESP.
REQ-019 IDLE: when ce_i_1 or ce_i_2 is high, latch both slots and pending bits p1 = ce_i_1, p2 = ce_i_2; next state is ISSUE1 if p1, else ISSUE2.
REQ-020 ISSUE1 shall drive the RAM with slot 1 for exactly one cycle; next state is ISSUE2 if p2, else RESP.
REQ-021 ISSUE2 shall drive the RAM with slot 2 for exactly one cycle; next state is RESP.
REQ-022 RESP shall assert resp_valid_o for one cycle with rdata held, ignore all ce_i inputs, and return to IDLE.
REQ-023 The RAM port shall be inactive outside ISSUE1/ISSUE2: ram_ce_o = 0, ram_we_o = 0, and all other RAM outputs 0.
REQ-024 Read data shall be captured in the cycle after its issue, into rdata_o_1 or rdata_o_2 according to slot.
REQ-025 rdata for a store slot or a non-requesting slot shall be 0.
REQ-026 stall_o = (IDLE and (ce_i_1 or ce_i_2)) or ISSUE1 or ISSUE2; stall_o = 0 in RESP.
REQ-027 Latency from acceptance to resp_valid_o shall be 2 cycles for one slot and 3 cycles for two slots.
REQ-028 Issue order shall always be slot 1 before slot 2, so a same-address store(1) followed by load(2) returns the new data.
REQ-029 flush_i in ISSUE1 or ISSUE2 shall drop every un-issued slot, suppress resp_valid_o, and move the FSM to IDLE next cycle.
REQ-030 A slot already driven to the RAM before a flush shall not be retracted.
REQ-031 flush_i in IDLE shall block acceptance in that cycle; flush_i in RESP shall have no effect.

Reset
REQ-032 On rst the FSM shall enter IDLE and p1, p2, stall_o, resp_valid_o, rdata_o_1/2, all ram_*_o and stall_cycles_o shall be 0.
REQ-033 rst asserted mid-operation shall abandon any outstanding request at the next edge with no RESP pulse.

Configuration
REQ-034 With DRAM_ARB_PERF_EN defined, stall_cycles_o shall increment by 1 on every cycle with stall_o = 1 and saturate at 0xFFFFFFFF.
REQ-035 Without DRAM_ARB_PERF_EN, stall_cycles_o shall be tied to 0 and no counter logic shall be built.

Verification
REQ-036 Single load: ce_i_1 = 1, addr 0x1c000010, RAM returns 0xDEADBEEF -> ISSUE1 one cycle later, resp_valid_o 2 cycles after acceptance, rdata_o_1 = 0xDEADBEEF, rdata_o_2 = 0.
REQ-037 Store(1) to 0x100 with data 0x12345678 and sel 0xF, plus load(2) from 0x100 -> RAM write precedes read, rdata_o_2 = 0x12345678, latency 3, stall_o high for 3 cycles.
REQ-038 Slot-2-only load -> FSM goes IDLE, ISSUE2, RESP; ram_pc_o = pc_i_2 during issue.
REQ-039 Both slots present, flush_i pulsed during ISSUE1 -> slot 1 write performed, slot 2 never issued, no resp_valid_o, IDLE next cycle.
REQ-040 rst pulsed during ISSUE2 -> all outputs 0 next cycle; with DRAM_ARB_PERF_EN, stall_cycles_o = 0 after reset and = 3 after one two-slot transaction.
